// File: rtl/ame_pkg.sv
// rtl/ame_pkg.sv - shared types and widths for the affine-ME numerator divider
package ame_pkg;

    localparam int AME_DATA_BITS = 64;

    typedef enum logic [1:0] {IDLE, CALC, FIN} ame_div_state_t;

    // Which result FIN publishes: normal quotient, divide-by-zero, or MIN / -1 saturation.
    typedef enum logic [1:0] {PATH_NORM, PATH_DZ, PATH_OVF} ame_div_path_t;

endpackage

// File: rtl/ame_num_divide_if.sv
// rtl/ame_num_divide_if.sv - request/result bundle between the ME controller and the divider
interface ame_num_divide_if
    import ame_pkg::*;
#(
    parameter int W = AME_DATA_BITS
);
    logic         div_init_i;
    logic [W-1:0] div_num_i;
    logic [W-1:0] div_den_i;
    logic         div_busy_o;
    logic         div_done_o;
    logic [W-1:0] div_quo_o;
    logic [W-1:0] div_rem_o;
    logic         div_dz_o;
    logic         div_ovf_o;

    modport master (
        output div_init_i, div_num_i, div_den_i,
        input  div_busy_o, div_done_o, div_quo_o, div_rem_o, div_dz_o, div_ovf_o
    );

    modport slave (
        input  div_init_i, div_num_i, div_den_i,
        output div_busy_o, div_done_o, div_quo_o, div_rem_o, div_dz_o, div_ovf_o
    );
endinterface

// File: rtl/ame_abs_sign.sv
// rtl/ame_abs_sign.sv - magnitude and sign of a two's complement operand
module ame_abs_sign #(
    parameter int W = 64
) (
    input  logic [W-1:0] val,
    output logic [W:0]   mag,
    output logic         neg
);
    logic [W:0] ext;

    // One extra bit so that |MIN| = 2^(W-1) is representable.
    assign ext = {val[W-1], val};
    assign neg = val[W-1];
    assign mag = neg ? -ext : ext;
endmodule

// File: rtl/ame_num_divide.sv
// rtl/ame_num_divide.sv - radix-2 non-performing signed divider, one quotient bit per clock
module ame_num_divide
    import ame_pkg::*;
#(
    parameter int COMP_DATA_BITS = AME_DATA_BITS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ame_num_divide_if.slave div_if
);
    localparam int N     = COMP_DATA_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    ame_div_state_t state;
    ame_div_path_t  path;

    logic [N:0]       num_mag;
    logic [N:0]       den_mag;
    logic             num_neg;
    logic             den_neg;
    logic [N:0]       divisor;
    logic [N:0]       prem;
    logic [N-1:0]     quo_acc;
    logic             rem_neg;
    logic             quo_neg;
    logic [CNT_W-1:0] cnt;
    logic [N+1:0]     trial;
    logic             den_zero;
    logic             ovf_case;

    ame_abs_sign #(.W(N)) u_num_abs (
        .val (div_if.div_num_i),
        .mag (num_mag),
        .neg (num_neg)
    );

    ame_abs_sign #(.W(N)) u_den_abs (
        .val (div_if.div_den_i),
        .mag (den_mag),
        .neg (den_neg)
    );

    assign den_zero = (div_if.div_den_i == '0);
    assign ovf_case = (div_if.div_num_i == MIN_NEG) && (&div_if.div_den_i);

    // Dividend bits stream out of quo_acc's MSB while quotient bits fill its LSB.
    assign trial = {prem, quo_acc[N-1]} - {1'b0, divisor};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            path              <= PATH_NORM;
            divisor           <= '0;
            prem              <= '0;
            quo_acc           <= '0;
            rem_neg           <= 1'b0;
            quo_neg           <= 1'b0;
            cnt               <= '0;
            div_if.div_busy_o <= 1'b0;
            div_if.div_done_o <= 1'b0;
            div_if.div_quo_o  <= '0;
            div_if.div_rem_o  <= '0;
            div_if.div_dz_o   <= 1'b0;
            div_if.div_ovf_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_if.div_done_o <= 1'b0;
                    // A request coinciding with the done pulse is dropped; it must be held or reissued.
                    if (div_if.div_init_i && !div_if.div_done_o) begin
                        divisor           <= den_mag;
                        quo_acc           <= num_mag[N-1:0];
                        rem_neg           <= num_neg;
                        quo_neg           <= num_neg ^ den_neg;
                        cnt               <= '0;
                        div_if.div_busy_o <= 1'b1;
                        if (den_zero) begin
                            prem  <= num_mag;
                            path  <= PATH_DZ;
                            state <= FIN;
                        end else if (ovf_case) begin
                            prem  <= '0;
                            path  <= PATH_OVF;
                            state <= FIN;
                        end else begin
                            prem  <= '0;
                            path  <= PATH_NORM;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem    <= trial[N+1] ? {prem[N-1:0], quo_acc[N-1]} : trial[N:0];
                    quo_acc <= {quo_acc[N-2:0], ~trial[N+1]};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    div_if.div_done_o <= 1'b1;
                    div_if.div_busy_o <= 1'b0;
                    state             <= IDLE;
                    case (path)
                        PATH_DZ: begin
                            div_if.div_quo_o <= '0;
                            div_if.div_rem_o <= rem_neg ? -prem[N-1:0] : prem[N-1:0];
                            div_if.div_dz_o  <= 1'b1;
                            div_if.div_ovf_o <= 1'b0;
                        end
                        PATH_OVF: begin
                            div_if.div_quo_o <= MAX_POS;
                            div_if.div_rem_o <= '0;
                            div_if.div_dz_o  <= 1'b0;
                            div_if.div_ovf_o <= 1'b1;
                        end
                        default: begin
                            div_if.div_quo_o <= quo_neg ? -quo_acc : quo_acc;
                            div_if.div_rem_o <= rem_neg ? -prem[N-1:0] : prem[N-1:0];
                            div_if.div_dz_o  <= 1'b0;
                            div_if.div_ovf_o <= 1'b0;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ame_num_divide.sv
// tb/tb_ame_num_divide.sv - self-checking bench for ame_num_divide
module tb_ame_num_divide;

    localparam longint MINV = 64'sh8000_0000_0000_0000;
    localparam longint MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;

    typedef struct {
        longint num;
        longint den;
        longint quo;
        longint rem;
        bit     dz;
        bit     ovf;
        int     lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[14];

    always #5 clk = ~clk;

    ame_num_divide_if #(.W(64)) dif ();

    ame_num_divide #(.COMP_DATA_BITS(64)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .div_if (dif)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input longint n, input longint d, input longint q, input longint r,
                                input bit dz, input bit ovf, input int lat);
        vec_t v;
        v.num = n; v.den = d; v.quo = q; v.rem = r; v.dz = dz; v.ovf = ovf; v.lat = lat;
        return v;
    endfunction

    // Reference: language-level signed division, with the two special results carved out first.
    function automatic vec_t model(input longint n, input longint d);
        if (d == 0)                  return mk(n, d, 0, n, 1'b1, 1'b0, 1);
        if (n == MINV && d == -1)    return mk(n, d, MAXV, 0, 1'b0, 1'b1, 1);
        return mk(n, d, n / d, n % d, 1'b0, 1'b0, 65);
    endfunction

    task automatic wait_done(input int limit, output int k, output int busy_cyc, output bit seen);
        k = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && k < limit) begin
            if (dif.div_busy_o) busy_cyc++;
            if (dif.div_done_o) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int k, busy_cyc;
        bit seen;
        logic [63:0] q_keep;
        @(negedge clk);
        dif.div_init_i = 1'b1;
        dif.div_num_i  = v.num;
        dif.div_den_i  = v.den;
        @(negedge clk);
        dif.div_init_i = 1'b0;
        wait_done(300, k, busy_cyc, seen);
        chk({tag, ".done_seen"}, seen, 1'b1);
        if (seen) begin
            chk({tag, ".quo"}, dif.div_quo_o, v.quo);
            chk({tag, ".rem"}, dif.div_rem_o, v.rem);
            chk({tag, ".dz"}, dif.div_dz_o, v.dz);
            chk({tag, ".ovf"}, dif.div_ovf_o, v.ovf);
            chk({tag, ".latency"}, k, v.lat);
            chk({tag, ".busy_cycles"}, busy_cyc, v.lat);
            q_keep = dif.div_quo_o;
            @(negedge clk);
            chk({tag, ".done_single"}, dif.div_done_o, 1'b0);
            chk({tag, ".quo_hold"}, dif.div_quo_o, q_keep);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int k, busy_cyc, ndone, dk;
        bit seen;
        longint n, d, q_first, r_first;

        tbl[0]  = mk(100, 7, 14, 2, 0, 0, 65);
        tbl[1]  = mk(-100, 7, -14, -2, 0, 0, 65);
        tbl[2]  = mk(100, -7, -14, 2, 0, 0, 65);
        tbl[3]  = mk(-100, -7, 14, -2, 0, 0, 65);
        tbl[4]  = mk(1234, 0, 0, 1234, 1, 0, 1);
        tbl[5]  = mk(MINV, -1, MAXV, 0, 0, 1, 1);
        tbl[6]  = mk(MINV, 1, MINV, 0, 0, 0, 65);
        tbl[7]  = mk(MINV, 0, 0, MINV, 1, 0, 1);
        tbl[8]  = mk(7, 100, 0, 7, 0, 0, 65);
        tbl[9]  = mk(-1, MINV, 0, -1, 0, 0, 65);
        tbl[10] = mk(MINV, MINV, 1, 0, 0, 0, 65);
        tbl[11] = mk(MAXV, -1, -MAXV, 0, 0, 0, 65);
        tbl[12] = mk(0, 5, 0, 0, 0, 0, 65);
        tbl[13] = mk(MAXV, 2, 64'sh3FFF_FFFF_FFFF_FFFF, 1, 0, 0, 65);

        dif.div_init_i = 1'b0;
        dif.div_num_i  = '0;
        dif.div_den_i  = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", dif.div_busy_o, 1'b0);
        chk("reset.done", dif.div_done_o, 1'b0);
        chk("reset.quo", dif.div_quo_o, 64'd0);
        chk("reset.rem", dif.div_rem_o, 64'd0);
        chk("reset.dz", dif.div_dz_o, 1'b0);
        chk("reset.ovf", dif.div_ovf_o, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i]);
        end

        for (int i = 0; i < 150; i++) begin
            n = {$urandom, $urandom};
            n = n >>> $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) n = MINV;
            case ($urandom_range(0, 3))
                0: d = longint'($urandom_range(0, 40)) - 20;
                1: d = {$urandom, $urandom};
                2: d = longint'(int'($urandom));
                default: begin
                    d = {$urandom, $urandom};
                    d = d >>> $urandom_range(1, 62);
                end
            endcase
            run_vec($sformatf("rnd%0d", i), model(n, d));
        end

        // Second init pulse at t0+10 while busy must be ignored.
        @(negedge clk);
        dif.div_init_i = 1'b1;
        dif.div_num_i  = 1000;
        dif.div_den_i  = 3;
        @(negedge clk);
        dif.div_init_i = 1'b0;
        ndone = 0; dk = -1; q_first = 0; r_first = 0;
        for (int j = 0; j < 100; j++) begin
            if (j == 9) begin
                dif.div_init_i = 1'b1;
                dif.div_num_i  = 5;
                dif.div_den_i  = 1;
            end
            if (j == 10) dif.div_init_i = 1'b0;
            if (dif.div_done_o) begin
                ndone++;
                if (dk < 0) begin
                    dk = j;
                    q_first = dif.div_quo_o;
                    r_first = dif.div_rem_o;
                end
            end
            @(negedge clk);
        end
        chk("busy_init.done_count", ndone, 1);
        chk("busy_init.latency", dk, 65);
        chk("busy_init.quo", q_first, 333);
        chk("busy_init.rem", r_first, 1);

        // Request raised during the done cycle: dropped there, accepted once held into IDLE.
        @(negedge clk);
        dif.div_init_i = 1'b1;
        dif.div_num_i  = 50;
        dif.div_den_i  = -6;
        @(negedge clk);
        dif.div_init_i = 1'b0;
        wait_done(300, k, busy_cyc, seen);
        chk("chain_a.done_seen", seen, 1'b1);
        chk("chain_a.quo", dif.div_quo_o, -64'sd8);
        dif.div_init_i = 1'b1;
        dif.div_num_i  = -77;
        dif.div_den_i  = 5;
        @(negedge clk);
        chk("chain_b.init_on_done_ignored", dif.div_busy_o, 1'b0);
        @(negedge clk);
        dif.div_init_i = 1'b0;
        wait_done(300, k, busy_cyc, seen);
        chk("chain_b.done_seen", seen, 1'b1);
        chk("chain_b.latency", k, 65);
        chk("chain_b.quo", dif.div_quo_o, -64'sd15);
        chk("chain_b.rem", dif.div_rem_o, -64'sd2);
        @(negedge clk);

        // Reset asserted ahead of edge t0+30 discards the request.
        dif.div_init_i = 1'b1;
        dif.div_num_i  = 999;
        dif.div_den_i  = 4;
        @(negedge clk);
        dif.div_init_i = 1'b0;
        repeat (29) @(negedge clk);
        chk("abort.busy_before", dif.div_busy_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort.busy", dif.div_busy_o, 1'b0);
        chk("abort.done", dif.div_done_o, 1'b0);
        chk("abort.quo", dif.div_quo_o, 64'd0);
        chk("abort.rem", dif.div_rem_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        busy_cyc = 0;
        for (int j = 0; j < 100; j++) begin
            if (dif.div_done_o) ndone++;
            if (dif.div_busy_o) busy_cyc++;
            @(negedge clk);
        end
        chk("abort.no_done", ndone, 0);
        chk("abort.no_busy", busy_cyc, 0);

        run_vec("after_abort", model(-123456789, 1000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
